// File: rtl/fg_config_bank.sv
// -----------------------------------------------------------------------------
// fg_config_bank
//
// Double-buffered configuration register bank for the function generator.
// Host writes arrive on a pad-level parallel bus with an asynchronous,
// active-low write strobe. They land in shadow registers. A commit copies the
// whole shadow image into the active bus in a single edge. A commit is either
// commanded through the CMD register or, in auto mode, taken at the next
// waveform period boundary. The generator therefore never sees a partially
// updated configuration in the middle of a period.
//
// Parameters
//   DATA_W       width of each config register and of the data bus
//   NUM_REGS     number of config registers (must be < 2**ADDR_W)
//   ADDR_W       address width; the all-ones address is the CMD register
//   SYNC_STAGES  flip-flop stages per strobe synchroniser (>= 2)
//   RESET_VALUES flat reset image, reg 0 in the MSBs
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous reset, active high
//   data_i         write data (host holds it stable around the strobe)
//   addr_i         write/read address (host holds it stable)
//   wr_n_async_i   asynchronous write strobe, active low
//   en_async_i     asynchronous generator enable
//   period_end_i   one-cycle pulse at a waveform period boundary
//   cr_bus_o       active configuration, reg 0 in the MSBs
//   enable_o       synchronised enable
//   cfg_update_o   one-cycle pulse in the cycle after every commit
//   pending_o      shadow holds writes that are not yet committed
//   addr_err_o     sticky flag, set by a write to an unmapped address
//   rd_data_o      registered readback (shadow, CMD status, or zero)
//
// CMD register write bits: bit0 commit now, bit1 auto-commit mode,
// bit2 clear addr_err. CMD readback: {0.., addr_err, pending, auto}.
// -----------------------------------------------------------------------------
module fg_config_bank #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 7,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES =
        {8'h49, 8'h05, 8'h00, 8'h00, 8'h00, 8'h32, 8'h00}
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic                         wr_n_async_i,
    input  logic                         en_async_i,
    input  logic                         period_end_i,
    output logic [NUM_REGS*DATA_W-1:0]   cr_bus_o,
    output logic                         enable_o,
    output logic                         cfg_update_o,
    output logic                         pending_o,
    output logic                         addr_err_o,
    output logic [DATA_W-1:0]            rd_data_o
);

    // The CMD register sits at the top of the address space.
    localparam logic [ADDR_W-1:0] CMD_ADDR    = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] NUM_REGS_A  = ADDR_W'(NUM_REGS);

    // Synchroniser and edge-detect state
    logic [SYNC_STAGES-1:0] wr_sync_r;
    logic                   wr_prev_r;
    logic [SYNC_STAGES-1:0] en_sync_r;

    // Register storage
    logic [DATA_W-1:0]      shadow_r [NUM_REGS];
    logic [DATA_W-1:0]      active_r [NUM_REGS];

    // Control / status state
    logic                   auto_r;
    logic                   pending_r;
    logic                   addr_err_r;
    logic                   cfg_update_r;
    logic [DATA_W-1:0]      rd_data_r;

    // Combinational decode
    logic                   wr_strobe_s;
    logic                   hit_reg_s;
    logic                   hit_cmd_s;
    logic                   reg_wr_s;
    logic                   cmd_wr_s;
    logic                   bad_wr_s;
    logic                   cmd_commit_s;
    logic                   auto_commit_s;
    logic                   commit_s;
    logic [DATA_W-1:0]      rd_mux_s;
    logic [NUM_REGS*DATA_W-1:0] cr_bus_s;

    // Write strobe synchroniser plus prev register. Stages reset to "strobe
    // active" so that a wr_n held low across reset release is not a write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sync_r <= {SYNC_STAGES{1'b1}};
            wr_prev_r <= 1'b1;
        end else begin
            wr_sync_r <= {wr_sync_r[SYNC_STAGES-2:0], ~wr_n_async_i};
            wr_prev_r <= wr_sync_r[SYNC_STAGES-1];
        end
    end

    // Enable synchroniser; its last stage drives enable_o directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            en_sync_r <= {en_sync_r[SYNC_STAGES-2:0], en_async_i};
        end
    end

    // Strobe qualification, address decode and commit arbitration.
    always_comb begin
        wr_strobe_s   = wr_sync_r[SYNC_STAGES-1] & ~wr_prev_r;
        hit_reg_s     = (addr_i < NUM_REGS_A);
        hit_cmd_s     = (addr_i == CMD_ADDR);
        reg_wr_s      = wr_strobe_s & hit_reg_s;
        cmd_wr_s      = wr_strobe_s & hit_cmd_s;
        bad_wr_s      = wr_strobe_s & ~hit_reg_s & ~hit_cmd_s;
        // A CMD commit ignores the mode bit; the auto path uses the mode
        // already stored, so both firing on one edge is still one commit.
        cmd_commit_s  = cmd_wr_s & data_i[0];
        auto_commit_s = period_end_i & auto_r & pending_r;
        commit_s      = cmd_commit_s | auto_commit_s;
    end

    // Shadow registers: host writes only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= RESET_VALUES[(NUM_REGS-1-i)*DATA_W +: DATA_W];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_wr_s && (addr_i == ADDR_W'(i))) begin
                    shadow_r[i] <= data_i;
                end
            end
        end
    end

    // Active registers: whole-image copy from shadow on commit. The copy uses
    // the shadow value from before any write landing on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_r[i] <= RESET_VALUES[(NUM_REGS-1-i)*DATA_W +: DATA_W];
            end
        end else begin
            if (commit_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    active_r[i] <= shadow_r[i];
                end
            end
        end
    end

    // Mode, pending, sticky error and commit pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            auto_r       <= 1'b0;
            pending_r    <= 1'b0;
            addr_err_r   <= 1'b0;
            cfg_update_r <= 1'b0;
        end else begin
            cfg_update_r <= commit_s;
            // A write coinciding with a commit is not part of that commit,
            // so it keeps the shadow marked as pending.
            if (reg_wr_s) begin
                pending_r <= 1'b1;
            end else if (commit_s) begin
                pending_r <= 1'b0;
            end
            if (cmd_wr_s) begin
                auto_r <= data_i[1];
            end
            if (bad_wr_s) begin
                addr_err_r <= 1'b1;
            end else if (cmd_wr_s && data_i[2]) begin
                addr_err_r <= 1'b0;
            end
        end
    end

    // Readback selection from the current address.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        if (hit_reg_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_mux_s = (addr_i == ADDR_W'(i)) ? shadow_r[i] : rd_mux_s;
            end
        end else if (hit_cmd_s) begin
            rd_mux_s = DATA_W'({addr_err_r, pending_r, auto_r});
        end else begin
            rd_mux_s = {DATA_W{1'b0}};
        end
    end

    // Readback register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_data_r <= rd_mux_s;
        end
    end

    // Pack the active registers onto the flat bus, reg 0 in the MSBs.
    always_comb begin
        cr_bus_s = {(NUM_REGS*DATA_W){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cr_bus_s[(NUM_REGS-1-i)*DATA_W +: DATA_W] = active_r[i];
        end
    end

    assign cr_bus_o     = cr_bus_s;
    assign enable_o     = en_sync_r[SYNC_STAGES-1];
    assign cfg_update_o = cfg_update_r;
    assign pending_o    = pending_r;
    assign addr_err_o   = addr_err_r;
    assign rd_data_o    = rd_data_r;

endmodule

// File: doc/fg_config_bank.md
# fg_config_bank

Parametrised, double-buffered configuration register bank for the function generator top level. It captures host writes from the pad-level parallel bus and synchronises the write and enable strobes. Writes land in shadow registers first, and a commit copies them into the active bus either on command or at the next waveform period boundary. Mid-period writes therefore never glitch the generator. It also provides readback, a pending flag and sticky address-error reporting.

## Interface
Parameters:
- `DATA_W`, 8, width of each config register and of the data bus
- `NUM_REGS`, 7, number of config registers; `NUM_REGS < 2**ADDR_W` is required
- `ADDR_W`, 3, address width; address `2**ADDR_W-1` is the command/status register (CMD)
- `SYNC_STAGES`, 2, flip-flop stages in each strobe synchroniser (≥2)
- `RESET_VALUES`, {8'h49,8'h05,8'h00,8'h00,8'h00,8'h32,8'h00}, flat `NUM_REGS*DATA_W` reset image; reg 0 occupies the MSBs

Ports:
- `clk_i`, in, 1, single clock; all logic on its rising edge
- `rst_i`, in, 1, synchronous reset, active high
- `data_i`, in, `DATA_W`, write data (not synchronised; host holds it stable)
- `addr_i`, in, `ADDR_W`, write/read address (not synchronised)
- `wr_n_async_i`, in, 1, asynchronous write strobe, active low
- `en_async_i`, in, 1, asynchronous generator enable
- `period_end_i`, in, 1, one-cycle pulse from the generator at a waveform period boundary
- `cr_bus_o`, out, `NUM_REGS*DATA_W`, active config; reg 0 in the MSBs
- `enable_o`, out, 1, synchronised enable
- `cfg_update_o`, out, 1, one-cycle pulse after every commit
- `pending_o`, out, 1, shadow holds uncommitted writes
- `addr_err_o`, out, 1, sticky; set by a write to an unmapped address
- `rd_data_o`, out, `DATA_W`, registered readback

## Operation
- Write detect:
  - `~wr_n_async_i` passes through a `SYNC_STAGES` synchroniser, then a prev-register.
  - The write strobe is `sync & ~prev`: one strobe per host write, however long `wr_n` stays low.
- Strobe with `addr_i < NUM_REGS`:
  - `shadow[addr_i] <= data_i`.
  - `pending` is set.
- Strobe with `addr_i` = CMD, decoded from `data_i`:
  - bit0 = commit now.
  - bit1 is stored as the auto-commit mode bit.
  - bit2 = clear `addr_err`.
  - Other bits are ignored.
- Strobe with any other address: `addr_err` is set. No register changes.
- Commit:
  - Every active register takes its shadow value, `pending` is cleared, and `cfg_update` pulses.
  - Triggered by CMD bit0 = 1 (always, even when `pending` = 0).
  - Also triggered by `period_end_i` = 1 while auto mode = 1 and `pending` = 1.
- Simultaneous events:
  - A commit and a shadow write on the same edge: active takes the pre-write shadow values, and `pending` stays set.
  - A CMD commit and an auto-commit on the same edge produce one commit and one pulse.
  - A CMD write with bit0 = 1 that also changes the mode bit commits regardless of the old mode.
- Readback (`rd_data_o` registered from `addr_i`):
  - `addr_i < NUM_REGS` returns `shadow[addr_i]`.
  - CMD returns {0…, `addr_err`, `pending`, auto}, with auto in bit0.
  - Any other address returns 0.
- Enable: `en_async_i` passes through its own `SYNC_STAGES` synchroniser to `enable_o`.
- Reset values:
  - Shadow and active = `RESET_VALUES`.
  - Auto mode = 0, `pending` = 0, `addr_err` = 0, `cfg_update_o` = 0, `rd_data_o` = 0, `enable_o` = 0.
  - The enable synchroniser resets to 0.
  - The write synchroniser stages and prev reset to 1. A `wr_n` held low across reset release therefore produces no write.
- Reset mid-operation: any in-flight strobe is discarded. The bank returns to the reset image on the edge where `rst_i` is sampled high.

## Timing
- Let edge 1 be the first edge that samples `wr_n` low. The write sync output is high after edge `SYNC_STAGES`, and the shadow or CMD effect is applied at edge `SYNC_STAGES+1`.
- The host holds `data_i`/`addr_i` stable from the `wr_n` fall through edge `SYNC_STAGES+2`.
- The host holds `wr_n` low for at least 1 clock and high for at least `SYNC_STAGES+1` clocks between writes.
- A CMD commit updates `cr_bus_o` at the same edge as the CMD write. `cfg_update_o` is high for exactly the following cycle.
- An auto-commit updates `cr_bus_o` at the edge that samples `period_end_i` = 1. `cfg_update_o` is high for the next cycle.
- `pending_o` is high from the edge after the shadow write until the commit edge.
- `enable_o` latency is `SYNC_STAGES` edges.
- `rd_data_o` has 1-cycle latency and reflects shadow contents updated on the prior edge.

## Test plan
- Reset, then hold `wr_n` low through release: `cr_bus_o` = 56'h49050000003200, and there is no write, `pending_o` = 0 and `rd_data_o` = 0.
- Write addr 2 = 8'hA5 in manual mode: `cr_bus_o` is unchanged and `pending_o` = 1. Reading addr 2 returns A5. A CMD write of 8'h01 then sets reg 2 = A5 on that edge, with one `cfg_update_o` pulse and `pending_o` = 0.
- Auto mode (CMD = 8'h02):
  - Write reg 5 = 8'h10: no change until `period_end_i`, then `cr_bus_o` reg 5 = 10 and one pulse.
  - `period_end_i` with `pending` = 0: no pulse.
- Write reg 1 on the same edge as an auto-commit: active reg 1 keeps its old value and `pending_o` stays 1. The next `period_end_i` commits it.
- Write addr 7 with `NUM_REGS` = 7 and `ADDR_W` = 4: `addr_err_o` = 1, no register changes, and CMD readback bit2 = 1. A CMD write of 8'h04 clears it.
- Hold `wr_n` low for 20 cycles: exactly one write. `en_async_i` toggles: `enable_o` follows after 2 edges. Assert `rst_i` mid-write: the strobe is lost and the reset image is restored.
